// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared definitions for the two-master Wishbone B4 classic arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE / ibus granted / dbus granted)
//   - M_IBUS/M_DBUS : master indices used by the round-robin `last` register
//   - grant_onehot : maps a state to the one-hot grant vector
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam logic M_IBUS = 1'b0;
    localparam logic M_DBUS = 1'b1;

    // Legal range of the watchdog limit.
    localparam int TIMEOUT_MIN = 1;
    localparam int TIMEOUT_MAX = 1023;

    // bit0 = ibus, bit1 = dbus, 00 while idle.
    function automatic logic [1:0] grant_onehot(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            ARB_GNT_I: g = 2'b01;
            ARB_GNT_D: g = 2'b10;
            default:   g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter_if
//   One Wishbone B4 classic point-to-point link.
//   Request  (master -> slave): adr[AW], dat[DW], sel[DW/8], we, cyc, stb
//   Response (slave -> master): rdt[DW], ack, err
//   Modports:
//     master : the side that issues the request (drives adr..stb)
//     slave  : the side that answers it (drives rdt/ack/err)
// -----------------------------------------------------------------------------
interface wb_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [DW-1:0]   rdt;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat, sel, we, cyc, stb,
        input  rdt, ack, err
    );

    modport slave (
        input  adr, dat, sel, we, cyc, stb,
        output rdt, ack, err
    );
endinterface

// File: rtl/wb_arb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_arb_watchdog
//   Stall counter for the arbiter. Counts cycles while `active` is high,
//   returns to zero on `clear`, and holds at TIMEOUT_CYCLES. `expired` is
//   high whenever the count equals TIMEOUT_CYCLES. Only instantiated when
//   WB_ARB_TIMEOUT_EN is defined.
//   Ports:
//     wb_clk   in  clock, rising edge
//     wb_rst_n in  synchronous active-low reset
//     active   in  stalled strobe outstanding this cycle
//     clear    in  restart count (ack/err seen, grant left, or expiry)
//     expired  out count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk,
    input  logic wb_rst_n,
    input  logic active,
    input  logic clear,
    output logic expired
);
    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (active && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = (r_count == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//   Two-master Wishbone B4 classic arbiter: the core's instruction master
//   (ibus) and data master (dbus) share one downstream bus. Round-robin
//   arbitration; the grant is held for the whole bus cycle (until the owner
//   drops cyc). Grant is registered, so a request seen in cycle N reaches the
//   slave in cycle N+1; the response path back to the owner is combinational.
//
//   Optional feature, macro WB_ARB_TIMEOUT_EN: a watchdog (wb_arb_watchdog)
//   terminates a strobe that has gone TIMEOUT_CYCLES without ack/err by
//   returning err to the owner, pulsing `timeout` and releasing the bus.
//   Without the macro no counter exists and `timeout` is tied to 0.
//
//   Ports:
//     wb_clk   in   clock, rising edge
//     wb_rst_n in   synchronous active-low reset
//     wb_ibus  slave modport  master 0 (instruction) request/response
//     wb_dbus  slave modport  master 1 (data) request/response
//     wb_s     master modport shared downstream bus
//     grant    out  one-hot owner: bit0 ibus, bit1 dbus, 00 idle
//     timeout  out  one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    wb_bus_arbiter_if.slave         wb_ibus,
    wb_bus_arbiter_if.slave         wb_dbus,
    wb_bus_arbiter_if.master        wb_s,
    output logic [1:0]              grant,
    output logic                    timeout
);

    if ((TIMEOUT_CYCLES < TIMEOUT_MIN) || (TIMEOUT_CYCLES > TIMEOUT_MAX)) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT_CYCLES out of range 1..1023");
    end

    arb_state_t r_state;
    logic       r_last;
    logic [1:0] r_grant;

    logic            w_req_i;
    logic            w_req_d;
    logic            w_gnt_i;
    logic            w_gnt_d;
    logic            w_in_gnt;
    logic            w_timeout;
    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_dat;
    logic [DW/8-1:0] w_sel;
    logic            w_we;
    logic            w_cyc;
    logic            w_stb;

    assign w_req_i  = wb_ibus.cyc & wb_ibus.stb;
    assign w_req_d  = wb_dbus.cyc & wb_dbus.stb;
    assign w_gnt_i  = (r_state == ARB_GNT_I);
    assign w_gnt_d  = (r_state == ARB_GNT_D);
    assign w_in_gnt = w_gnt_i | w_gnt_d;

    // Arbitration FSM. Grant is decided only from registered state, so there
    // is no combinational path from a request to the grant.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= M_IBUS;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    // On a tie the master that was not served last wins.
                    if (w_req_i && (!w_req_d || (r_last == M_DBUS))) begin
                        r_state <= ARB_GNT_I;
                        r_grant <= grant_onehot(ARB_GNT_I);
                    end else if (w_req_d) begin
                        r_state <= ARB_GNT_D;
                        r_grant <= grant_onehot(ARB_GNT_D);
                    end
                end
                ARB_GNT_I: begin
                    if (!wb_ibus.cyc || w_timeout) begin
                        r_state <= ARB_IDLE;
                        r_last  <= M_IBUS;
                        r_grant <= grant_onehot(ARB_IDLE);
                    end
                end
                ARB_GNT_D: begin
                    if (!wb_dbus.cyc || w_timeout) begin
                        r_state <= ARB_IDLE;
                        r_last  <= M_DBUS;
                        r_grant <= grant_onehot(ARB_IDLE);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // Request mux: owner's request straight through, all zero while idle.
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_cyc = 1'b0;
        w_stb = 1'b0;
        case (r_state)
            ARB_GNT_I: begin
                w_adr = wb_ibus.adr;
                w_dat = wb_ibus.dat;
                w_sel = wb_ibus.sel;
                w_we  = wb_ibus.we;
                w_cyc = wb_ibus.cyc;
                w_stb = wb_ibus.stb;
            end
            ARB_GNT_D: begin
                w_adr = wb_dbus.adr;
                w_dat = wb_dbus.dat;
                w_sel = wb_dbus.sel;
                w_we  = wb_dbus.we;
                w_cyc = wb_dbus.cyc;
                w_stb = wb_dbus.stb;
            end
            default: ;
        endcase
    end

    assign wb_s.adr = w_adr;
    assign wb_s.dat = w_dat;
    assign wb_s.sel = w_sel;
    assign wb_s.we  = w_we;
    // An expiring cycle is withdrawn from the slave in the same cycle.
    assign wb_s.cyc = w_cyc & ~w_timeout;
    assign wb_s.stb = w_stb & ~w_timeout;

    // Read data is broadcast; only the owner gets ack/err.
    assign wb_ibus.rdt = wb_s.rdt;
    assign wb_dbus.rdt = wb_s.rdt;
    assign wb_ibus.ack = w_gnt_i & wb_s.ack;
    assign wb_dbus.ack = w_gnt_d & wb_s.ack;
    assign wb_ibus.err = w_gnt_i & (wb_s.err | w_timeout);
    assign wb_dbus.err = w_gnt_d & (wb_s.err | w_timeout);

`ifdef WB_ARB_TIMEOUT_EN
    logic w_wd_active;
    logic w_wd_clear;
    logic w_wd_expired;

    assign w_wd_active = w_in_gnt & w_stb & ~wb_s.ack & ~wb_s.err;
    // Clearing on expiry restarts the count while the FSM drops to IDLE.
    assign w_wd_clear  = ~w_in_gnt | wb_s.ack | wb_s.err | w_timeout;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .active   (w_wd_active),
        .clear    (w_wd_clear),
        .expired  (w_wd_expired)
    );

    // A slave ack landing on the expiry cycle wins; no error then.
    assign w_timeout = w_wd_expired & w_in_gnt & ~wb_s.ack;
`else
    assign w_timeout = 1'b0;
`endif

    assign grant   = r_grant;
    assign timeout = w_timeout;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    wb_bus_arbiter_if #(.AW(AW), .DW(DW)) ibus_if ();
    wb_bus_arbiter_if #(.AW(AW), .DW(DW)) dbus_if ();
    wb_bus_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    wb_bus_arbiter #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk   (clk),
        .wb_rst_n (rst_n),
        .wb_ibus  (ibus_if),
        .wb_dbus  (dbus_if),
        .wb_s     (s_if),
        .grant    (grant),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        ibus_if.adr = '0; ibus_if.dat = '0; ibus_if.sel = '0; ibus_if.we = 1'b0;
        ibus_if.cyc = 1'b0; ibus_if.stb = 1'b0;
        dbus_if.adr = '0; dbus_if.dat = '0; dbus_if.sel = '0; dbus_if.we = 1'b0;
        dbus_if.cyc = 1'b0; dbus_if.stb = 1'b0;
        s_if.rdt = '0; s_if.ack = 1'b0; s_if.err = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        settle();
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_s_cyc"}, s_if.cyc, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
        rst_n = 1'b1;
    endtask

    // Round-robin stimulus: per-cycle cyc/stb of each master, slave ack and
    // the grant expected in that cycle.
    logic       rr_i [12] = '{1,1,1,1,1,0,1,1,1,1,1,0};
    logic       rr_d [12] = '{1,1,0,1,1,1,1,1,0,1,1,1};
    logic       rr_a [12] = '{0,1,0,0,1,0,0,1,0,0,1,0};
    logic [1:0] rr_g [12] = '{2'b00,2'b10,2'b10,2'b00,2'b01,2'b01,
                              2'b00,2'b10,2'b10,2'b00,2'b01,2'b01};

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic seen_err;
        idle_inputs();

        // ---- single ibus read ----
        do_reset("rst0");
        next_cycle();
        ibus_if.adr = 32'h0000_0010; ibus_if.sel = 4'hF;
        ibus_if.cyc = 1'b1; ibus_if.stb = 1'b1;
        settle();
        check("rd_c0_grant", grant, 2'b00);
        check("rd_c0_s_cyc", s_if.cyc, 1'b0);
        next_cycle(); settle();
        check("rd_c1_grant", grant, 2'b01);
        check("rd_c1_s_adr", s_if.adr, 32'h10);
        check("rd_c1_s_stb", s_if.stb, 1'b1);
        next_cycle(); settle();
        check("rd_c2_ibus_ack", ibus_if.ack, 1'b0);
        next_cycle();
        s_if.ack = 1'b1; s_if.rdt = 32'hDEAD_BEEF;
        settle();
        check("rd_c3_ibus_ack", ibus_if.ack, 1'b1);
        check("rd_c3_ibus_rdt", ibus_if.rdt, 32'hDEAD_BEEF);
        check("rd_c3_dbus_ack", dbus_if.ack, 1'b0);
        next_cycle();
        s_if.ack = 1'b0; ibus_if.cyc = 1'b0; ibus_if.stb = 1'b0;
        settle();
        check("rd_c4_grant", grant, 2'b01);
        next_cycle(); settle();
        check("rd_c5_grant", grant, 2'b00);
        check("rd_c5_s_adr", s_if.adr, 32'h0);

        // ---- tie after reset ----
        do_reset("rst1");
        next_cycle();
        ibus_if.adr = 32'h100; ibus_if.cyc = 1'b1; ibus_if.stb = 1'b1;
        dbus_if.adr = 32'h200; dbus_if.cyc = 1'b1; dbus_if.stb = 1'b1;
        settle();
        next_cycle();
        s_if.ack = 1'b1;
        settle();
        check("tie_c1_grant", grant, 2'b10);
        check("tie_c1_s_adr", s_if.adr, 32'h200);
        check("tie_c1_dbus_ack", dbus_if.ack, 1'b1);
        check("tie_c1_ibus_ack", ibus_if.ack, 1'b0);
        next_cycle();
        s_if.ack = 1'b0; dbus_if.cyc = 1'b0; dbus_if.stb = 1'b0;
        settle();
        check("tie_c2_grant", grant, 2'b10);
        next_cycle(); settle();
        check("tie_c3_grant", grant, 2'b00);
        check("tie_c3_s_cyc", s_if.cyc, 1'b0);
        next_cycle(); settle();
        check("tie_c4_grant", grant, 2'b01);
        check("tie_c4_s_adr", s_if.adr, 32'h100);

        // ---- round robin ----
        do_reset("rst2");
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            ibus_if.cyc = rr_i[c]; ibus_if.stb = rr_i[c];
            dbus_if.cyc = rr_d[c]; dbus_if.stb = rr_d[c];
            s_if.ack = rr_a[c];
            settle();
            check($sformatf("rr_c%0d_grant", c), grant, rr_g[c]);
            check($sformatf("rr_c%0d_ibus_ack", c), ibus_if.ack, rr_a[c] & (rr_g[c] == 2'b01));
            check($sformatf("rr_c%0d_dbus_ack", c), dbus_if.ack, rr_a[c] & (rr_g[c] == 2'b10));
        end
        next_cycle();
        idle_inputs();
        settle();
        check("rr_c12_grant", grant, 2'b00);

        // ---- held grant across a 3-beat dbus cycle ----
        do_reset("rst3");
        next_cycle();
        ibus_if.cyc = 1'b1; ibus_if.stb = 1'b1;
        dbus_if.cyc = 1'b1; dbus_if.stb = 1'b1;
        settle();
        for (int b = 1; b <= 3; b++) begin
            next_cycle();
            s_if.ack = 1'b1;
            settle();
            check($sformatf("hold_b%0d_grant", b), grant, 2'b10);
            check($sformatf("hold_b%0d_dbus_ack", b), dbus_if.ack, 1'b1);
            check($sformatf("hold_b%0d_ibus_ack", b), ibus_if.ack, 1'b0);
        end
        next_cycle();
        s_if.ack = 1'b0; dbus_if.cyc = 1'b0; dbus_if.stb = 1'b0;
        settle();
        check("hold_c4_grant", grant, 2'b10);
        next_cycle(); settle();
        check("hold_c5_grant", grant, 2'b00);
        next_cycle(); settle();
        check("hold_c6_grant", grant, 2'b01);

        // ---- stalled dbus write ----
        do_reset("rst4");
        next_cycle();
        dbus_if.adr = 32'h40; dbus_if.dat = 32'h1234_5678; dbus_if.sel = 4'hF;
        dbus_if.we = 1'b1; dbus_if.cyc = 1'b1; dbus_if.stb = 1'b1;
        settle();
        next_cycle(); settle();
        check("wd_c1_grant", grant, 2'b10);
        check("wd_c1_s_dat", s_if.dat, 32'h1234_5678);
        check("wd_c1_s_we", s_if.we, 1'b1);
`ifdef WB_ARB_TIMEOUT_EN
        seen_err = 1'b0;
        for (int k = 2; k <= TO; k++) begin
            next_cycle(); settle();
            seen_err = seen_err | dbus_if.err | timeout;
        end
        check("wd_pre_expiry_err", seen_err, 1'b0);
        next_cycle(); settle();
        check("wd_exp_dbus_err", dbus_if.err, 1'b1);
        check("wd_exp_timeout", timeout, 1'b1);
        check("wd_exp_s_cyc", s_if.cyc, 1'b0);
        check("wd_exp_s_stb", s_if.stb, 1'b0);
        check("wd_exp_ibus_err", ibus_if.err, 1'b0);
        next_cycle(); settle();
        check("wd_post_grant", grant, 2'b00);
        check("wd_post_timeout", timeout, 1'b0);
        check("wd_post_dbus_err", dbus_if.err, 1'b0);
`else
        seen_err = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            next_cycle(); settle();
            seen_err = seen_err | dbus_if.err | ibus_if.err | timeout;
        end
        check("nowd_err_seen", seen_err, 1'b0);
        check("nowd_grant_locked", grant, 2'b10);
`endif

        // ---- reset during a stalled ibus cycle ----
        do_reset("rst5");
        next_cycle();
        ibus_if.cyc = 1'b1; ibus_if.stb = 1'b1;
        settle();
        next_cycle();
        s_if.err = 1'b1;
        settle();
        check("rst_c1_grant", grant, 2'b01);
        check("rst_c1_ibus_err", ibus_if.err, 1'b1);
        check("rst_c1_dbus_err", dbus_if.err, 1'b0);
        next_cycle();
        s_if.err = 1'b0; rst_n = 1'b0;
        settle();
        check("rst_c2_grant_sync", grant, 2'b01);
        next_cycle();
        s_if.ack = 1'b1;
        settle();
        check("rst_c3_grant", grant, 2'b00);
        check("rst_c3_s_cyc", s_if.cyc, 1'b0);
        check("rst_c3_ibus_ack", ibus_if.ack, 1'b0);
        check("rst_c3_dbus_ack", dbus_if.ack, 1'b0);
        check("rst_c3_timeout", timeout, 1'b0);
        s_if.ack = 1'b0;
        rst_n = 1'b1;
        idle_inputs();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
